// File: rtl/uart_tx_scheduler_pkg.sv
// ============================================================================
// Module  : uart_tx_scheduler_pkg
// Brief   : Shared constants and FSM encoding for the UART TX scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_scheduler_pkg;

  // UART word addresses (bits [4:2] of the byte address)
  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_LSR    = 3'd1;

  // LSR bit that reads 1 when the transmitter is idle
  localparam int         LSR_TS_BIT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POLL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GUARD = 2'd3
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_byte_fifo.sv
// ============================================================================
// Module  : uart_byte_fifo
// Brief   : Byte FIFO with wrap-around pointers and an occupancy counter.
//           Head byte is presented combinationally on dout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_byte_fifo #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // Count reaches DEPTH only when full, so its MSB alone flags full.
  assign full  = count_q[DEPTH_LOG2];
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Qualify push/pop; a push into a full FIFO is only taken alongside a pop.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are don't-care while the count says empty.
  always_ff @(posedge CLK_I) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module  : uart_tx_scheduler
// Brief   : Round-robin sharing of the MiniUART transmitter between two byte
//           producers; WISHBONE master that polls LSR then writes DATA.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int GUARD_CYC  = 3
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic        busy,
  output logic [2:0]  M_ADD_O,
  output logic [31:0] M_DAT_O,
  input  logic [31:0] M_DAT_I,
  output logic        M_STB_O,
  output logic        M_WE_O,
  input  logic        M_ACK_I
);

  sched_state_e state_q, state_d;
  logic         rr_q, rr_d;
  logic [7:0]   byte_q, byte_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         stb_q, stb_d;
  logic         we_q, we_d;
  logic [2:0]   add_q, add_d;
  logic [31:0]  dat_q, dat_d;

  logic         pop0, pop1, grant;
  logic [7:0]   dout0, dout1;
  logic         full0, full1, empty0, empty1;

  // Only the TS bit of LSR matters to this block.
  logic         unused_lsr_bits;
  assign unused_lsr_bits = ^{M_DAT_I[31:LSR_TS_BIT+1], M_DAT_I[LSR_TS_BIT-1:0]};

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo0 (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (req0_valid & req0_ready),
    .pop   (pop0),
    .din   (req0_data),
    .dout  (dout0),
    .full  (full0),
    .empty (empty0)
  );

  uart_byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo1 (
    .CLK_I (CLK_I),
    .RST_I (RST_I),
    .push  (req1_valid & req1_ready),
    .pop   (pop1),
    .din   (req1_data),
    .dout  (dout1),
    .full  (full1),
    .empty (empty1)
  );

  assign req0_ready = ~full0;
  assign req1_ready = ~full1;
  assign busy       = ~empty0 | ~empty1 | (state_q != ST_IDLE);
  assign M_STB_O    = stb_q;
  assign M_WE_O     = we_q;
  assign M_ADD_O    = add_q;
  assign M_DAT_O    = dat_q;

  // Next-state and registered bus outputs; everything holds unless changed.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    byte_d  = byte_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    we_d    = we_q;
    add_d   = add_q;
    dat_d   = dat_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty0 || !empty1) begin
          // rr=0 prefers requester 0; fall back to the other when empty.
          grant   = rr_q ? ~empty1 : empty0;
          pop0    = ~grant;
          pop1    = grant;
          byte_d  = grant ? dout1 : dout0;
          rr_d    = ~grant;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          add_d   = OFF_LSR;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        if (M_ACK_I && M_DAT_I[LSR_TS_BIT]) begin
          we_d    = 1'b1;
          add_d   = OFF_DATA;
          dat_d   = {24'b0, byte_q};
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (M_ACK_I) begin
          stb_d   = 1'b0;
          we_d    = 1'b0;
          cnt_d   = 4'(GUARD_CYC);
          state_d = ST_GUARD;
        end
      end
      ST_GUARD: begin
        if (cnt_q <= 4'd1) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus immediately.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      byte_q  <= 8'd0;
      cnt_q   <= 4'd0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      add_q   <= 3'd0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      byte_q  <= byte_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      add_q   <= add_d;
      dat_q   <= dat_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ============================================================================
// Module  : tb_uart_tx_scheduler
// Brief   : Self-checking bench for uart_tx_scheduler with a UART slave model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int GUARD = 3;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [7:0]  req0_data = 8'd0, req1_data = 8'd0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready, busy;
  logic [2:0]  M_ADD_O;
  logic [31:0] M_DAT_O, M_DAT_I;
  logic        M_STB_O, M_WE_O, M_ACK_I;

  int n_checks = 0;
  int n_fail   = 0;

  // UART slave model state
  int cyc = 0;
  int wr_wait = 0;
  int write_stall = 0;
  int lsr_reads_total = 0;
  int lsr_busy_until = 0;
  bit rand_busy = 1'b0;
  int proto_err = 0;
  int we_cycles = 0;

  typedef struct { logic [31:0] dat; int edge_n; } wr_t;
  wr_t wq[$];
  int  rq[$];

  uart_tx_scheduler #(.DEPTH_LOG2(2), .GUARD_CYC(GUARD)) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .busy       (busy),
    .M_ADD_O    (M_ADD_O),
    .M_DAT_O    (M_DAT_O),
    .M_DAT_I    (M_DAT_I),
    .M_STB_O    (M_STB_O),
    .M_WE_O     (M_WE_O),
    .M_ACK_I    (M_ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  // Slave: reads are acked at once, writes after write_stall cycles.
  assign M_ACK_I = M_STB_O & (!M_WE_O | (wr_wait >= write_stall));
  assign M_DAT_I = ((lsr_reads_total < lsr_busy_until) || rand_busy) ? 32'h0000_0000 : 32'h0000_0020;

  // Slave bookkeeping advanced on the bus clock.
  always @(posedge CLK_I) begin
    cyc <= cyc + 1;
    if (M_STB_O && M_ACK_I && !M_WE_O) lsr_reads_total <= lsr_reads_total + 1;
    if (M_STB_O && M_WE_O && !M_ACK_I) wr_wait <= wr_wait + 1;
    else                               wr_wait <= 0;
  end

  // Bus monitor: logs completed cycles, flags dropped STB or unstable outputs.
  logic       pend = 1'b0, p_we = 1'b0;
  logic [2:0] p_add = 3'd0;
  logic [31:0] p_dat = 32'd0;
  always @(negedge CLK_I) begin
    if (RST_I) begin
      pend = 1'b0;
    end else begin
      if (pend && (!M_STB_O || M_WE_O !== p_we || M_ADD_O !== p_add || M_DAT_O !== p_dat))
        proto_err++;
      if (M_STB_O && M_WE_O) we_cycles++;
      if (M_STB_O && M_ACK_I) begin
        if (M_WE_O) begin
          if (M_ADD_O !== 3'd0) proto_err++;
          wq.push_back('{M_DAT_O, cyc + 1});
        end else begin
          if (M_ADD_O !== 3'd1) proto_err++;
          rq.push_back(cyc + 1);
        end
        pend = 1'b0;
      end else if (M_STB_O) begin
        pend = 1'b1; p_we = M_WE_O; p_add = M_ADD_O; p_dat = M_DAT_O;
      end else begin
        pend = 1'b0;
      end
    end
  end

  task automatic wait_writes(input int n, input int bound, output bit ok);
    int k = 0;
    while (wq.size() < n && k < bound) begin @(negedge CLK_I); k++; end
    ok = (wq.size() >= n);
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int k = 0;
    while (busy && k < bound) begin @(negedge CLK_I); k++; end
    ok = !busy;
  endtask

  task automatic push_one(input bit sel, input logic [7:0] d);
    @(negedge CLK_I);
    if (sel) begin req1_valid = 1'b1; req1_data = d; end
    else     begin req0_valid = 1'b1; req0_data = d; end
    @(negedge CLK_I);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    int k, n_before;
    RST_I = 1'b1;
    repeat (3) @(negedge CLK_I);
    n_checks++;
    if ({M_STB_O, M_WE_O, M_ADD_O} !== 5'b0) begin
      n_fail++; $display("FAIL reset_bus: stb/we/add=%b required 00000", {M_STB_O, M_WE_O, M_ADD_O});
    end
    n_checks++;
    if (M_DAT_O !== 32'd0) begin n_fail++; $display("FAIL reset_dat: got %h required 0", M_DAT_O); end
    n_checks++;
    if ({req0_ready, req1_ready, busy} !== 3'b110) begin
      n_fail++; $display("FAIL reset_flags: ready0/ready1/busy=%b required 110", {req0_ready, req1_ready, busy});
    end
    RST_I = 1'b0;
    // Reset in the middle of a stalled DATA write
    write_stall = 1000;
    push_one(1'b0, 8'h77);
    k = 0;
    while (!(M_STB_O && M_WE_O) && k < 20) begin @(negedge CLK_I); k++; end
    n_checks++;
    if (!(M_STB_O && M_WE_O)) begin n_fail++; $display("FAIL reset_reach_write: stb=%b we=%b required 1 1", M_STB_O, M_WE_O); end
    n_before = wq.size();
    #1 RST_I = 1'b1;
    #1;
    n_checks++;
    if ({M_STB_O, M_WE_O, req0_ready, req1_ready, busy} !== 5'b00110) begin
      n_fail++; $display("FAIL reset_async: stb/we/r0/r1/busy=%b required 00110", {M_STB_O, M_WE_O, req0_ready, req1_ready, busy});
    end
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    write_stall = 0;
    repeat (20) @(negedge CLK_I);
    n_checks++;
    if (wq.size() !== n_before || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_discard: writes=%0d busy=%b required %0d 0", wq.size(), busy, n_before);
    end
  endtask

  task automatic test_single();
    int n;
    bit ok;
    wq.delete(); rq.delete();
    @(negedge CLK_I);
    n = cyc + 1;
    req0_valid = 1'b1; req0_data = 8'h41;
    @(negedge CLK_I);
    req0_data = 8'h42;
    @(negedge CLK_I);
    req0_valid = 1'b0;
    wait_writes(2, 60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_timeout: writes=%0d required 2", wq.size()); end
    else begin
      n_checks++;
      if (wq[0].dat !== 32'h41) begin n_fail++; $display("FAIL single_data0: got %h required 00000041", wq[0].dat); end
      n_checks++;
      if (wq[0].edge_n !== n + 3) begin n_fail++; $display("FAIL single_write_edge: got %0d required %0d", wq[0].edge_n, n + 3); end
      n_checks++;
      if (rq[0] !== n + 2) begin n_fail++; $display("FAIL single_lsr_edge: got %0d required %0d", rq[0], n + 2); end
      n_checks++;
      if (rq.size() < 2 || rq[1] < n + 4 + GUARD) begin
        n_fail++; $display("FAIL single_guard: second poll edge %0d required >= %0d", (rq.size() > 1) ? rq[1] : -1, n + 4 + GUARD);
      end
      n_checks++;
      if (wq[1].dat !== 32'h42) begin n_fail++; $display("FAIL single_data1: got %h required 00000042", wq[1].dat); end
    end
  endtask

  task automatic test_busy_uart();
    bit ok;
    wq.delete(); rq.delete();
    @(negedge CLK_I);
    lsr_busy_until = lsr_reads_total + 5;
    push_one(1'b0, 8'h55);
    wait_writes(1, 60, ok);
    repeat (10) @(negedge CLK_I);
    n_checks++;
    if (rq.size() !== 6) begin n_fail++; $display("FAIL busy_polls: got %0d required 6", rq.size()); end
    n_checks++;
    if (wq.size() !== 1 || (ok && wq[0].dat !== 32'h55)) begin
      n_fail++; $display("FAIL busy_write: count=%0d required 1 of 00000055", wq.size());
    end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL busy_protocol: errors=%0d required 0", proto_err); end
  endtask

  task automatic test_fairness();
    bit ok;
    logic [7:0] exp_b;
    RST_I = 1'b1;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    wq.delete(); rq.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_I);
      req0_valid = 1'b1; req0_data = 8'h10 + 8'(i);
      req1_valid = 1'b1; req1_data = 8'h20 + 8'(i);
    end
    @(negedge CLK_I);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_writes(8, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL fair_timeout: writes=%0d required 8", wq.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        exp_b = ((i % 2) == 0 ? 8'h10 : 8'h20) + 8'(i / 2);
        n_checks++;
        if (wq[i].dat !== {24'b0, exp_b}) begin
          n_fail++; $display("FAIL fair_order[%0d]: got %h required %h", i, wq[i].dat, {24'b0, exp_b});
        end
      end
    end
  endtask

  task automatic test_full_fifo();
    int acc = 0;
    int k = 0;
    bit ok;
    wq.delete(); rq.delete();
    @(negedge CLK_I);
    lsr_busy_until = lsr_reads_total + 100000;
    push_one(1'b1, 8'h30);
    repeat (2) @(negedge CLK_I);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_I);
      req0_data  = 8'hA0 + 8'(acc);
      req0_valid = (acc < 5);
      if (req0_valid && req0_ready) acc++;
    end
    n_checks++;
    if (acc !== 4 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_refuse: accepted=%0d ready0=%b required 4 0", acc, req0_ready);
    end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b required 1", busy); end
    lsr_busy_until = lsr_reads_total;
    while (acc < 5 && k < 40) begin
      @(negedge CLK_I);
      req0_data  = 8'hA0 + 8'(acc);
      req0_valid = 1'b1;
      if (req0_ready) acc++;
      k++;
    end
    @(negedge CLK_I);
    req0_valid = 1'b0;
    n_checks++;
    if (acc !== 5) begin n_fail++; $display("FAIL full_release: accepted=%0d required 5", acc); end
    wait_writes(6, 200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL full_timeout: writes=%0d required 6", wq.size()); end
    else begin
      n_checks++;
      if (wq[0].dat !== 32'h30) begin n_fail++; $display("FAIL full_first: got %h required 00000030", wq[0].dat); end
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (wq[i+1].dat !== 32'hA0 + i) begin
          n_fail++; $display("FAIL full_order[%0d]: got %h required %h", i, wq[i+1].dat, 32'hA0 + i);
        end
      end
    end
  endtask

  task automatic test_ack_stall();
    bit ok;
    wq.delete(); rq.delete();
    @(negedge CLK_I);
    write_stall = 3;
    we_cycles   = 0;
    push_one(1'b1, 8'h66);
    wait_writes(1, 60, ok);
    repeat (10) @(negedge CLK_I);
    write_stall = 0;
    n_checks++;
    if (wq.size() !== 1 || (ok && wq[0].dat !== 32'h66)) begin
      n_fail++; $display("FAIL stall_write: count=%0d required 1 of 00000066", wq.size());
    end
    n_checks++;
    if (we_cycles !== 4) begin n_fail++; $display("FAIL stall_we_cycles: got %0d required 4", we_cycles); end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL stall_protocol: errors=%0d required 0", proto_err); end
  endtask

  task automatic test_random();
    logic [7:0] q0[$], q1[$];
    logic [6:0] seq0 = 7'd0, seq1 = 7'd0;
    logic [7:0] b, e;
    bit ok;
    int total;
    wq.delete(); rq.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK_I);
      rand_busy   = ($urandom_range(0, 3) == 0);
      write_stall = $urandom_range(0, 2);
      req0_valid  = $urandom_range(0, 1) == 1;
      req1_valid  = $urandom_range(0, 1) == 1;
      req0_data   = {1'b0, seq0};
      req1_data   = {1'b1, seq1};
      if (req0_valid && req0_ready) begin q0.push_back(req0_data); seq0++; end
      if (req1_valid && req1_ready) begin q1.push_back(req1_data); seq1++; end
    end
    @(negedge CLK_I);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rand_busy = 1'b0; write_stall = 0;
    total = q0.size() + q1.size();
    wait_idle(3000, ok);
    repeat (2) @(negedge CLK_I);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rand_drain: busy=%b required 0", busy); end
    n_checks++;
    if (wq.size() !== total) begin n_fail++; $display("FAIL rand_count: writes=%0d required %0d", wq.size(), total); end
    foreach (wq[i]) begin
      b = wq[i].dat[7:0];
      if (b[7]) e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
      else      e = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
      n_checks++;
      if (wq[i].dat !== {24'b0, e}) begin
        n_fail++; $display("FAIL rand_byte[%0d]: got %h required %h", i, wq[i].dat, {24'b0, e});
      end
    end
    n_checks++;
    if (proto_err !== 0) begin n_fail++; $display("FAIL rand_protocol: errors=%0d required 0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_busy_uart();
    test_fairness();
    test_full_fifo();
    test_ack_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
